// File: rtl/cu_mc_if.sv
// Control-unit bundle: instruction/flags/ready in, datapath control out.
// The slave modport is the control unit's view; master is the datapath/driver view.
interface cu_mc_if #(
    parameter int IW = 16,
    parameter int RA = 4
);
    logic [IW-1:0]   ins_in;
    logic            z_in;
    logic            n_in;
    logic            mem_ready_in;
    logic            il_out;
    logic [1:0]      ps_out;
    logic            rw_out;
    logic [3*RA-1:0] rs_out;
    logic            mm_out;
    logic [1:0]      md_out;
    logic            mb_out;
    logic [3:0]      fs_out;
    logic            wen_out;
    logic            iom_out;
    logic            halt_out;
    logic            err_out;

    modport slave (
        input  ins_in, z_in, n_in, mem_ready_in,
        output il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
               wen_out, iom_out, halt_out, err_out
    );

    modport master (
        output ins_in, z_in, n_in, mem_ready_in,
        input  il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
               wen_out, iom_out, halt_out, err_out
    );
endinterface

// File: rtl/cu_mc.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT with memory wait states and
// a bus-timeout watchdog that parks the unit in HALT with a sticky error.
module cu_mc #(
    parameter int IW      = 16,
    parameter int RA      = 4,
    parameter int MAXWAIT = 15
) (
    input  logic    clk,
    input  logic    rst_n,
    cu_mc_if.slave  bus
);
    // One bit minimum so MAXWAIT=0 (watchdog off) still elaborates.
    localparam int CW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAXWAIT);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          err;

    logic [3:0] op;
    logic       ready, in_acc, timeout, is_mem, is_io, is_load;

    assign op      = bus.ins_in[IW-1:IW-4];
    assign ready   = bus.mem_ready_in;
    assign is_mem  = (op[3:2] == 2'b10);
    assign is_io   = op[1];
    assign is_load = ~op[0];
    assign in_acc  = (state == FETCH) || (state == MEM);
    // Ready on the limit cycle wins: the access completes without error.
    assign timeout = (MAXWAIT != 0) && in_acc && !ready && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            if (in_acc && !ready && nxt == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (timeout)
                err <= 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            FETCH: begin
                if (ready)        nxt = EXEC;
                else if (timeout) nxt = HALT;
            end
            EXEC: begin
                if (op == 4'hF)   nxt = HALT;
                else if (is_mem)  nxt = MEM;
                else              nxt = FETCH;
            end
            MEM: begin
                if (ready)        nxt = FETCH;
                else if (timeout) nxt = HALT;
            end
            default:              nxt = HALT;
        endcase
    end

    always_comb begin
        bus.il_out   = 1'b0;
        bus.ps_out   = 2'b00;
        bus.rw_out   = 1'b0;
        bus.mm_out   = 1'b0;
        bus.md_out   = 2'b00;
        bus.mb_out   = 1'b0;
        bus.fs_out   = 4'b0000;
        bus.wen_out  = 1'b0;
        bus.iom_out  = 1'b0;
        bus.halt_out = (state == HALT);
        bus.err_out  = err;
        bus.rs_out   = bus.ins_in[3*RA-1:0];
        case (state)
            FETCH: begin
                bus.mm_out = 1'b1;
                bus.il_out = ready;
            end
            EXEC: begin
                case (op)
                    4'h0: bus.ps_out = 2'b01;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        bus.rw_out = 1'b1;
                        bus.ps_out = 2'b01;
                        bus.mb_out = (op == 4'h7);
                        case (op)
                            4'h2, 4'h7: bus.fs_out = 4'b0010;
                            4'h3:       bus.fs_out = 4'b0101;
                            4'h4:       bus.fs_out = 4'b1000;
                            4'h5:       bus.fs_out = 4'b1001;
                            4'h6:       bus.fs_out = 4'b1010;
                            default:    bus.fs_out = 4'b0000;
                        endcase
                    end
                    4'h8, 4'h9, 4'hA, 4'hB: bus.iom_out = is_io;
                    4'hC: bus.ps_out = bus.z_in ? 2'b10 : 2'b01;
                    4'hD: bus.ps_out = bus.n_in ? 2'b10 : 2'b01;
                    4'hE: bus.ps_out = 2'b11;
                    default: ;
                endcase
            end
            MEM: begin
                bus.iom_out = is_io;
                if (is_load) bus.md_out  = 2'b01;
                else         bus.wen_out = 1'b1;
                if (ready) begin
                    bus.ps_out = 2'b01;
                    bus.rw_out = is_load;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cu_mc.sv
// Bench for cu_mc: decode table, hand-written wait/timeout/reset sequences and
// randomized instruction streams checked against a transaction-level model.
module tb_cu_mc;
    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;

    cu_mc_if #(.IW(16), .RA(4)) bus ();
    cu_mc_if #(.IW(16), .RA(3)) bus3 ();

    cu_mc #(.IW(16), .RA(4), .MAXWAIT(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    cu_mc #(.IW(16), .RA(3))              dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Packed view: il ps rw mm md mb fs wen iom halt err
    function automatic logic [15:0] pk(input logic il, input logic [1:0] ps, input logic rw,
                                       input logic mm, input logic [1:0] md, input logic mb,
                                       input logic [3:0] fs, input logic wen, input logic iom,
                                       input logic halt, input logic err);
        return {il, ps, rw, mm, md, mb, fs, wen, iom, halt, err};
    endfunction

    function automatic logic [15:0] act();
        return {bus.il_out, bus.ps_out, bus.rw_out, bus.mm_out, bus.md_out, bus.mb_out,
                bus.fs_out, bus.wen_out, bus.iom_out, bus.halt_out, bus.err_out};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Entered at posedge+1; drives ready, checks at negedge, returns at posedge+1.
    task automatic cyc(input logic rdy, input logic [15:0] e, input string nm);
        bus.mem_ready_in = rdy;
        @(negedge clk);
        chk(nm, 32'(act()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        bus.mem_ready_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: expected outputs per instruction phase, from the ISA table.
    function automatic logic [3:0] alu_fs(input logic [3:0] op);
        case (op)
            4'h2, 4'h7: return 4'b0010;
            4'h3:       return 4'b0101;
            4'h4:       return 4'b1000;
            4'h5:       return 4'b1001;
            4'h6:       return 4'b1010;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] mdl_exec(input logic [3:0] op, input logic z, input logic n);
        if (op == 0)             return pk(0, 2'b01, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0);
        if (op >= 1 && op <= 7)  return pk(0, 2'b01, 1, 0, 2'b00, op == 7, alu_fs(op), 0, 0, 0, 0);
        if (op >= 8 && op <= 11) return pk(0, 2'b00, 0, 0, 2'b00, 0, 4'h0, 0, op >= 10, 0, 0);
        if (op == 12)            return pk(0, z ? 2'b10 : 2'b01, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0);
        if (op == 13)            return pk(0, n ? 2'b10 : 2'b01, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0);
        if (op == 14)            return pk(0, 2'b11, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] mdl_mem(input logic [3:0] op, input logic rdy);
        logic load, io;
        load = (op == 8) || (op == 10);
        io   = (op >= 10);
        return pk(0, rdy ? 2'b01 : 2'b00, load && rdy, 0, load ? 2'b01 : 2'b00, 0, 4'h0,
                  !load, io, 0, 0);
    endfunction

    typedef struct {
        logic [15:0] ins;
        logic        z, n;
        logic [15:0] ex;
        logic [15:0] nx;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [15:0] f0, fil, hlt;
        f0  = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        fil = pk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        hlt = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        tbl[0]  = '{16'h2123, 0, 0, pk(0, 1, 1, 0, 0, 0, 4'b0010, 0, 0, 0, 0), f0};
        tbl[1]  = '{16'h1456, 0, 0, pk(0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[2]  = '{16'h3ABC, 1, 1, pk(0, 1, 1, 0, 0, 0, 4'b0101, 0, 0, 0, 0), f0};
        tbl[3]  = '{16'h4001, 0, 0, pk(0, 1, 1, 0, 0, 0, 4'b1000, 0, 0, 0, 0), f0};
        tbl[4]  = '{16'h5FFF, 0, 0, pk(0, 1, 1, 0, 0, 0, 4'b1001, 0, 0, 0, 0), f0};
        tbl[5]  = '{16'h6777, 0, 0, pk(0, 1, 1, 0, 0, 0, 4'b1010, 0, 0, 0, 0), f0};
        tbl[6]  = '{16'h7123, 0, 0, pk(0, 1, 1, 0, 0, 1, 4'b0010, 0, 0, 0, 0), f0};
        tbl[7]  = '{16'h0000, 0, 0, pk(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[8]  = '{16'hC000, 1, 0, pk(0, 2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[9]  = '{16'hC000, 0, 1, pk(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[10] = '{16'hD000, 0, 1, pk(0, 2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[11] = '{16'hD000, 1, 0, pk(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[12] = '{16'hE340, 0, 0, pk(0, 3, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), f0};
        tbl[13] = '{16'h8450, 0, 0, 16'h0000, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{16'hB010, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                    pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
        tbl[15] = '{16'hF000, 0, 0, 16'h0000, hlt};

        rst_n = 1'b0;
        bus.ins_in = '0;  bus.z_in = 0;  bus.n_in = 0;  bus.mem_ready_in = 0;
        bus3.ins_in = '0; bus3.z_in = 0; bus3.n_in = 0; bus3.mem_ready_in = 0;
        @(posedge clk);
        #1;

        // Outputs while held in reset
        @(negedge clk);
        chk("rst_idle", 32'(act()), 32'(f0));
        bus.mem_ready_in = 1'b1;
        #1;
        chk("rst_il_follows_ready", 32'(act()), 32'(fil));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decode table: FETCH, EXEC, then the first cycle of the following state
        for (int i = 0; i < 16; i++) begin
            rst_pulse();
            bus.ins_in = tbl[i].ins;
            bus.z_in   = tbl[i].z;
            bus.n_in   = tbl[i].n;
            cyc(1'b1, fil, $sformatf("tbl%0d_fetch", i));
            cyc(1'($urandom), tbl[i].ex, $sformatf("tbl%0d_exec", i));
            chk($sformatf("tbl%0d_rs", i), 32'(bus.rs_out), 32'(tbl[i].ins[11:0]));
            cyc(1'b0, tbl[i].nx, $sformatf("tbl%0d_next", i));
        end

        // LD with 3 wait states in MEM
        rst_pulse();
        bus.ins_in = 16'h8450;
        cyc(1'b1, fil, "ld_fetch");
        cyc(1'b0, 16'h0000, "ld_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "ld_wait");
        cyc(1'b1, pk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), "ld_done");
        cyc(1'b0, f0, "ld_back_fetch");

        // OUT timeout in MEM: 5 waiting cycles, then HALT with error
        rst_pulse();
        bus.ins_in = 16'hB010;
        cyc(1'b1, fil, "to_fetch");
        cyc(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "to_exec");
        for (int i = 0; i < 5; i++)
            cyc(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "to_mem_wait");
        cyc(1'($urandom), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "to_halt_err");

        // Ready on the limit cycle completes the access with no error
        rst_pulse();
        cyc(1'b0, f0, "err_cleared_by_reset");
        cyc(1'b1, fil, "lim_fetch");
        cyc(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "lim_exec");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "lim_wait");
        cyc(1'b1, pk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0), "lim_ready_wins");
        cyc(1'b0, f0, "lim_no_err");

        // Timeout while fetching
        rst_pulse();
        for (int i = 0; i < 5; i++)
            cyc(1'b0, f0, "fto_wait");
        cyc(1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "fto_halt_err");

        // HALT holds for 20 cycles regardless of ready
        rst_pulse();
        bus.ins_in = 16'hF000;
        cyc(1'b1, fil, "hlt_fetch");
        cyc(1'b1, 16'h0000, "hlt_exec");
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom), hlt, "hlt_stay");

        // Reset mid-ST drops wen immediately; restart in FETCH without error
        rst_pulse();
        bus.ins_in = 16'h9000;
        cyc(1'b1, fil, "st_fetch");
        cyc(1'b0, 16'h0000, "st_exec");
        #2;
        chk("st_wen_before_rst", 32'(bus.wen_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("st_wen_async_drop", 32'(bus.wen_out), 32'd0);
        chk("st_in_reset", 32'(act()), 32'(f0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, f0, "st_post_rst_fetch");

        // RA=3 instance: 9-bit register fields, ADDI decode
        rst_pulse();
        bus3.ins_in = 16'h71FF;
        bus3.mem_ready_in = 1'b1;
        @(negedge clk);
        chk("ra3_il", 32'(bus3.il_out), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ra3_mb", 32'(bus3.mb_out), 32'd1);
        chk("ra3_fs", 32'(bus3.fs_out), 32'h2);
        chk("ra3_rw_ps", 32'({bus3.rw_out, bus3.ps_out}), 32'h5);
        chk("ra3_rs", 32'(bus3.rs_out), 32'h1FF);
        @(posedge clk);
        #1;
        bus3.mem_ready_in = 1'b0;

        // Random instruction stream against the model; waits stay under the limit
        rst_pulse();
        for (int k = 0; k < 120; k++) begin
            logic [3:0] op;
            int wf, wm;
            op = 4'($urandom_range(0, 14));
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            bus.ins_in = {op, 12'($urandom)};
            bus.z_in   = 1'($urandom);
            bus.n_in   = 1'($urandom);
            for (int w = 0; w < wf; w++)
                cyc(1'b0, f0, "rnd_fetch_wait");
            cyc(1'b1, fil, "rnd_fetch");
            cyc(1'($urandom), mdl_exec(op, bus.z_in, bus.n_in), $sformatf("rnd_exec_op%0h", op));
            if (op >= 8 && op <= 11) begin
                for (int w = 0; w < wm; w++)
                    cyc(1'b0, mdl_mem(op, 1'b0), $sformatf("rnd_mem_wait_op%0h", op));
                cyc(1'b1, mdl_mem(op, 1'b1), $sformatf("rnd_mem_done_op%0h", op));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cu_mc.md
# cu_mc

Parametrised multi-cycle successor to the single-cycle control unit `cu` in `mycpu`. It adds memory/I-O wait-state handling, a bus-timeout watchdog, an explicit halt state, and configurable instruction and register-address widths. It decodes the instruction register contents on `ins_in` and the ALU flags, and drives the same datapath control bundle as `cu`, plus `mem_ready_in`, `halt_out` and `err_out`.

## Interface
- `IW`, 16: instruction width. Must satisfy `IW >= 3*RA+4`.
- `RA`, 4: register address width. `rs_out` is `3*RA` bits wide.
- `MAXWAIT`, 15: maximum wait cycles on `mem_ready_in` before timeout. 0 disables the timeout.
- `clk` in 1: clock, the only clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ins_in` in IW: instruction register contents. Opcode is `ins_in[IW-1:IW-4]`. Fields are D `[3RA-1:2RA]`, A `[2RA-1:RA]`, B `[RA-1:0]`.
- `z_in`, `n_in` in 1: zero and negative flags.
- `mem_ready_in` in 1: memory/I-O access completes this cycle.
- `il_out` out 1: load instruction register.
- `ps_out` out 2: PC select. 00 hold, 01 increment, 10 branch (PC+offset), 11 jump (PC←R[A]).
- `rw_out` out 1: register file write.
- `rs_out` out 3RA: {D,A,B}. Combinational pass-through of the fields in every state.
- `mm_out` out 1: address source. 1 = PC, 0 = R[A].
- `md_out` out 2: writeback mux. 00 = function unit, 01 = memory/I-O data.
- `mb_out` out 1: B operand. 1 = constant from instruction.
- `fs_out` out 4: function select.
- `wen_out` out 1: memory/I-O write enable.
- `iom_out` out 1: 1 selects I/O space.
- `halt_out` out 1: in HALT.
- `err_out` out 1: sticky timeout flag.

## Operation
- Idle values apply in every state unless overridden: `il`=0, `ps`=00, `rw`=0, `mm`=0, `md`=00, `mb`=0, `fs`=0000, `wen`=0, `iom`=0.
- States are FETCH, EXEC, MEM and HALT. Reset enters FETCH, clears the wait counter and clears `err_out`.
- FETCH:
  - Drives `mm`=1.
  - When `mem_ready_in`=1: `il`=1, next state EXEC.
  - Otherwise stays in FETCH and the wait counter increments.
- EXEC, by opcode:
  - 0 NOP: `ps`=01.
  - 1 MOV: `fs` 0000.
  - 2 ADD: `fs` 0010.
  - 3 SUB: `fs` 0101.
  - 4 AND: `fs` 1000.
  - 5 OR: `fs` 1001.
  - 6 XOR: `fs` 1010.
  - 7 ADDI: `fs` 0010, `mb`=1.
  - Opcodes 1–7 all assert `rw`=1 and `ps`=01, then go to FETCH.
  - 8 LD, 9 ST, A IN, B OUT: `mm`=0, `iom`=1 for A/B, next state MEM.
  - C BZ: `ps`=10 if `z_in`, otherwise 01.
  - D BN: `ps`=10 if `n_in`, otherwise 01.
  - E JMP: `ps`=11.
  - Opcodes C–E go to FETCH next.
  - F HALT: `ps`=00, next state HALT.
- MEM:
  - Drives `mm`=0 and `iom` as in EXEC.
  - LD/IN: `md`=01.
  - ST/OUT: `wen`=1 for every MEM cycle.
  - On `mem_ready_in`=1: `rw`=1 for LD/IN, `ps`=01, next state FETCH.
- HALT: all outputs idle, `halt_out`=1. Left only by reset.
- Wait counter:
  - Width is `$clog2(MAXWAIT+1)`.
  - Counts consecutive FETCH/MEM cycles with `mem_ready_in`=0.
  - Cleared on any state change and on ready.
  - If the count equals MAXWAIT (nonzero) while `mem_ready_in`=0: next state HALT, `err_out`←1.
  - `mem_ready_in` arriving in the same cycle as the limit wins: the access completes and there is no error.
- `mem_ready_in` is ignored in EXEC and HALT.

## Timing
- Register-to-register ALU, branch and jump instructions take 2 cycles with zero wait states. Memory/I-O instructions take 3 cycles, plus 1 cycle per wait state in either FETCH or MEM.
- All control outputs are combinational from state, `ins_in`, flags and `mem_ready_in`. `il_out`, `rw_out` and `ps_out`=01 in FETCH/MEM depend on `mem_ready_in` in the same cycle.
- State, counter and `err_out` update on `posedge clk`.
- While `rst_n`=0: state FETCH, so `mm_out`=1 and all other outputs are idle, `il_out` follows `mem_ready_in`, `halt_out`=0 and `err_out`=0.
- Reset asserted mid-MEM aborts the access immediately (`wen` drops asynchronously). The first cycle after release is FETCH.
- `ins_in` must be stable from the cycle after `il_out` until the EXEC/MEM sequence completes.

## Test plan
- Reset, then ADD `ins`=0x2123 with `mem_ready`=1:
  - FETCH: `il`=1, `mm`=1.
  - EXEC: `rw`=1, `fs`=0010, `ps`=01, `rs`=0x123.
  - Back in FETCH on cycle 3.
- LD `ins`=0x8450 with 3 wait states in MEM:
  - 3 cycles of `mm`=0, `md`=01, `rw`=0.
  - 4th MEM cycle: `rw`=1, `ps`=01.
- BZ `ins`=0xC000:
  - `z`=1 gives `ps`=10.
  - Rerun with `z`=0 gives `ps`=01.
  - BN with `n`=1 gives `ps`=10.
  - JMP gives `ps`=11.
- OUT `ins`=0xB010 with MAXWAIT=4 and `mem_ready` held low:
  - `wen`=1, `iom`=1 for 5 cycles.
  - Then HALT with `halt`=1 and `err`=1.
  - Repeat with ready arriving on the limit cycle: no error.
- HALT `ins`=0xF000: stays in HALT for 20 cycles with `ps`=00. Asserting `rst_n`=0 mid-ST in MEM: `wen` drops immediately, and after release the unit is in FETCH with `err`=0.
- Instantiate with RA=3, IW=16:
  - `rs_out` is 9 bits.
  - ADDI `ins`=0x71FF gives `mb`=1, `fs`=0010, `rs`=0x1FF.
